// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

  // Ops 000..011 are the iterative ones; bit 1 picks divide, bit 0 picks unsigned.
  function automatic logic is_md_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude extraction on entry and sign restoration of the raw
// unsigned result on exit.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_signed,
  input  logic               is_mul,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic [WIDTH-1:0]   rs_mag,
  output logic [WIDTH-1:0]   rt_mag,
  output logic               neg_lo,
  output logic               neg_hi,
  input  logic               res_is_mul,
  input  logic               res_neg_lo,
  input  logic               res_neg_hi,
  input  logic               res_div0,
  input  logic [WIDTH-1:0]   res_rs_raw,
  input  logic [2*WIDTH-1:0] res_acc,
  output logic [WIDTH-1:0]   hi_res,
  output logic [WIDTH-1:0]   lo_res
);

  logic             rs_neg, rt_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign rs_neg = is_signed & rs_val[WIDTH-1];
  assign rt_neg = is_signed & rt_val[WIDTH-1];
  // -2^(W-1) maps onto itself, which is the correct unsigned magnitude.
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // For MUL neg_lo negates the whole product; for DIV it is the quotient sign.
  assign neg_lo = rs_neg ^ rt_neg;
  assign neg_hi = rs_neg & ~is_mul;

  assign prod = res_neg_lo ? -res_acc : res_acc;
  assign quo  = res_neg_lo ? -res_acc[WIDTH-1:0] : res_acc[WIDTH-1:0];
  assign rem  = res_neg_hi ? -res_acc[2*WIDTH-1:WIDTH] : res_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    hi_res = rem;
    lo_res = quo;
    if (res_is_mul) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else if (res_div0) begin
      hi_res = res_rs_raw;
      lo_res = '1;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one result bit per cycle, WIDTH
// iterations plus a sign-fix cycle; holds the architectural HI/LO pair.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   rs_raw_q;
  logic               is_mul_q, neg_lo_q, neg_hi_q, div0_q;

  logic               launch;
  logic [WIDTH-1:0]   rs_mag, rt_mag, hi_res, lo_res;
  logic               neg_lo, neg_hi;
  logic [WIDTH:0]     mul_sum, div_rsh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign launch = start && is_md_op(op);
  assign busy   = (state_q != IDLE);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_signed  (~op[0]),
    .is_mul     (~op[1]),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .rs_mag     (rs_mag),
    .rt_mag     (rt_mag),
    .neg_lo     (neg_lo),
    .neg_hi     (neg_hi),
    .res_is_mul (is_mul_q),
    .res_neg_lo (neg_lo_q),
    .res_neg_hi (neg_hi_q),
    .res_div0   (div0_q),
    .res_rs_raw (rs_raw_q),
    .res_acc    (acc),
    .hi_res     (hi_res),
    .lo_res     (lo_res)
  );

  // Shift-add: multiplier sits in acc's low half and drains out the bottom.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: remainder in the high half, dividend/quotient in the low half.
  assign div_rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_rsh - {1'b0, m_q};
  assign div_next = div_diff[WIDTH] ? {div_rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (launch) state_d = op[1] ? DIV : MUL;
      MUL, DIV: if (cnt == LAST) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      m_q      <= '0;
      rs_raw_q <= '0;
      is_mul_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            cnt      <= '0;
            is_mul_q <= ~op[1];
            neg_lo_q <= neg_lo;
            neg_hi_q <= neg_hi;
            div0_q   <= op[1] && (rt_val == '0);
            rs_raw_q <= rs_val;
            m_q      <= op[1] ? rt_mag : rs_mag;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
          end else if (start && op == MDU_MTHI) begin
            hi <= rs_val;
          end else if (start && op == MDU_MTLO) begin
            lo <= rs_val;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi   <= hi_res;
          lo   <= lo_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
